// File: rtl/mem_rr_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory,
// with a full-array zero-fill sweep that stalls both requesters while it runs.
module mem_rr_arbiter #(
  parameter int AddrWidth = 4,
  parameter int DataWidth = 4
) (
  input  logic                 Clk_i,
  input  logic                 Reset_n_i,
  input  logic                 Req0_i,
  input  logic                 We0_i,
  input  logic [AddrWidth-1:0] Addr0_i,
  input  logic [DataWidth-1:0] Data0_i,
  output logic                 Gnt0_o,
  output logic                 RdValid0_o,
  output logic [DataWidth-1:0] RdData0_o,
  input  logic                 Req1_i,
  input  logic                 We1_i,
  input  logic [AddrWidth-1:0] Addr1_i,
  input  logic [DataWidth-1:0] Data1_i,
  output logic                 Gnt1_o,
  output logic                 RdValid1_o,
  output logic [DataWidth-1:0] RdData1_o,
  input  logic                 Clear_i,
  output logic                 Busy_o,
  output logic                 ClearDone_o,
  output logic [AddrWidth-1:0] Mem_Addr_o,
  output logic [DataWidth-1:0] Mem_Data_o,
  output logic                 Mem_WR_o,
  input  logic [DataWidth-1:0] Mem_Data_i
);

  localparam int                   Size     = 2 ** AddrWidth;
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Size - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_ptr;          // 0: port 0 wins a tie, 1: port 1 wins
  logic                 w_ptr_next;
  logic [AddrWidth-1:0] r_cnt;
  logic [AddrWidth-1:0] w_cnt_next;
  logic                 r_rdv0;
  logic                 r_rdv1;
  logic                 r_done;
  logic                 w_done_next;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_busy;
  logic [AddrWidth-1:0] w_mem_addr;
  logic [DataWidth-1:0] w_mem_data;
  logic                 w_mem_wr;

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      r_state <= ST_RUN;
      r_ptr   <= 1'b0;
      r_cnt   <= '0;
      r_rdv0  <= 1'b0;
      r_rdv1  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
      r_rdv0  <= w_gnt0 & ~We0_i;
      r_rdv1  <= w_gnt1 & ~We1_i;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_busy       = 1'b0;
    w_mem_addr   = '0;
    w_mem_data   = '0;
    w_mem_wr     = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (Clear_i) begin
          // A pending clear takes the whole cycle; requesters simply wait.
          w_state_next = ST_CLEAR;
          w_cnt_next   = '0;
        end else begin
          if (Req0_i && (!Req1_i || !r_ptr)) begin
            w_gnt0 = 1'b1;
          end else if (Req1_i) begin
            w_gnt1 = 1'b1;
          end

          if (w_gnt0) begin
            w_ptr_next = 1'b1;
            w_mem_addr = Addr0_i;
            w_mem_data = Data0_i;
            w_mem_wr   = We0_i;
          end else if (w_gnt1) begin
            w_ptr_next = 1'b0;
            w_mem_addr = Addr1_i;
            w_mem_data = Data1_i;
            w_mem_wr   = We1_i;
          end
        end
      end

      ST_CLEAR: begin
        w_busy     = 1'b1;
        w_mem_wr   = 1'b1;
        w_mem_addr = r_cnt;
        w_mem_data = '0;
        w_cnt_next = r_cnt + AddrWidth'(1);
        if (r_cnt == LastAddr) begin
          w_state_next = ST_RUN;
          w_done_next  = 1'b1;
        end
      end

      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  assign Gnt0_o      = w_gnt0;
  assign Gnt1_o      = w_gnt1;
  assign RdValid0_o  = r_rdv0;
  assign RdValid1_o  = r_rdv1;
  // Memory read data is already registered; both ports see it, valid qualifies.
  assign RdData0_o   = Mem_Data_i;
  assign RdData1_o   = Mem_Data_i;
  assign Busy_o      = w_busy;
  assign ClearDone_o = r_done;
  assign Mem_Addr_o  = w_mem_addr;
  assign Mem_Data_o  = w_mem_data;
  assign Mem_WR_o    = w_mem_wr;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a behavioural single-port memory
// (registered read, read-before-write) attached to the memory port.
module tb_mem_rr_arbiter;

  localparam int AW = 4;
  localparam int DW = 4;

  logic          Clk_i = 1'b0;
  logic          Reset_n_i;
  logic          Req0_i, We0_i, Req1_i, We1_i, Clear_i;
  logic [AW-1:0] Addr0_i, Addr1_i;
  logic [DW-1:0] Data0_i, Data1_i;
  logic          Gnt0_o, Gnt1_o, RdValid0_o, RdValid1_o;
  logic [DW-1:0] RdData0_o, RdData1_o;
  logic          Busy_o, ClearDone_o, Mem_WR_o;
  logic [AW-1:0] Mem_Addr_o;
  logic [DW-1:0] Mem_Data_o;
  logic [DW-1:0] Mem_Data_i;

  logic [DW-1:0] mem [2**AW];

  int checks   = 0;
  int failures = 0;

  always #5 Clk_i = ~Clk_i;

  always @(posedge Clk_i) begin
    Mem_Data_i <= mem[Mem_Addr_o];
    if (Mem_WR_o) mem[Mem_Addr_o] <= Mem_Data_o;
  end

  mem_rr_arbiter #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .Clk_i      (Clk_i),
    .Reset_n_i  (Reset_n_i),
    .Req0_i     (Req0_i),
    .We0_i      (We0_i),
    .Addr0_i    (Addr0_i),
    .Data0_i    (Data0_i),
    .Gnt0_o     (Gnt0_o),
    .RdValid0_o (RdValid0_o),
    .RdData0_o  (RdData0_o),
    .Req1_i     (Req1_i),
    .We1_i      (We1_i),
    .Addr1_i    (Addr1_i),
    .Data1_i    (Data1_i),
    .Gnt1_o     (Gnt1_o),
    .RdValid1_o (RdValid1_o),
    .RdData1_o  (RdData1_o),
    .Clear_i    (Clear_i),
    .Busy_o     (Busy_o),
    .ClearDone_o(ClearDone_o),
    .Mem_Addr_o (Mem_Addr_o),
    .Mem_Data_o (Mem_Data_o),
    .Mem_WR_o   (Mem_WR_o),
    .Mem_Data_i (Mem_Data_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 time units later.
  task automatic tick();
    @(posedge Clk_i);
    @(negedge Clk_i);
  endtask

  task automatic settle(input string what);
    #2;
    $display("t=%0t %s: gnt=%b%b rdv=%b%b rd=%h/%h busy=%b done=%b mem wr=%b a=%h d=%h",
             $time, what, Gnt1_o, Gnt0_o, RdValid1_o, RdValid0_o, RdData1_o, RdData0_o,
             Busy_o, ClearDone_o, Mem_WR_o, Mem_Addr_o, Mem_Data_o);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'((i % 15) + 1);
    Mem_Data_i = '0;
    Reset_n_i = 1'b0;
    Req0_i = 0; We0_i = 0; Addr0_i = '0; Data0_i = '0;
    Req1_i = 0; We1_i = 0; Addr1_i = '0; Data1_i = '0;
    Clear_i = 0;

    // Reset and idle
    tick(); tick();
    settle("reset");
    check("rst_gnt0", Gnt0_o, 0);
    check("rst_gnt1", Gnt1_o, 0);
    check("rst_busy", Busy_o, 0);
    check("rst_rdv0", RdValid0_o, 0);
    Reset_n_i = 1'b1;
    tick();
    settle("idle");
    check("idle_gnt", {Gnt1_o, Gnt0_o}, 0);
    check("idle_rdv", {RdValid1_o, RdValid0_o}, 0);
    check("idle_wr", Mem_WR_o, 0);
    check("idle_addr", Mem_Addr_o, 0);
    check("idle_done", ClearDone_o, 0);

    // Port 0 write 3<=A, then read back in the very next cycle
    Req0_i = 1; We0_i = 1; Addr0_i = 4'd3; Data0_i = 4'hA;
    settle("p0 write");
    check("wr_gnt0", Gnt0_o, 1);
    check("wr_gnt1", Gnt1_o, 0);
    check("wr_memwr", Mem_WR_o, 1);
    check("wr_addr", Mem_Addr_o, 3);
    check("wr_data", Mem_Data_o, 4'hA);
    tick();
    We0_i = 0; Data0_i = '0;
    settle("p0 read");
    check("rd_gnt0", Gnt0_o, 1);
    check("rd_memwr", Mem_WR_o, 0);
    check("wr_no_rdv", RdValid0_o, 0);
    tick();
    Req0_i = 0;
    settle("p0 read return");
    check("rd_rdv0", RdValid0_o, 1);
    check("rd_data0", RdData0_o, 4'hA);
    check("rd_rdv1", RdValid1_o, 0);
    check("rd_idle_gnt", {Gnt1_o, Gnt0_o}, 0);

    // Lone port 1 read of addr 5 moves the pointer back to port 0
    tick();
    Req1_i = 1; We1_i = 0; Addr1_i = 4'd5;
    settle("p1 read");
    check("p1_gnt1", Gnt1_o, 1);
    check("p1_gnt0", Gnt0_o, 0);
    check("p1_addr", Mem_Addr_o, 5);

    // Contention: both read (p0 addr1 = 2, p1 addr2 = 3) for 4 cycles
    tick();
    Req0_i = 1; We0_i = 0; Addr0_i = 4'd1; Addr1_i = 4'd2;
    settle("contend c0");
    check("c0_gnt", {Gnt1_o, Gnt0_o}, 2'b01);
    check("c0_addr", Mem_Addr_o, 1);
    check("c0_rdv1", RdValid1_o, 1);
    check("c0_data1", RdData1_o, 6);
    tick();
    settle("contend c1");
    check("c1_gnt", {Gnt1_o, Gnt0_o}, 2'b10);
    check("c1_addr", Mem_Addr_o, 2);
    check("c1_rdv", {RdValid1_o, RdValid0_o}, 2'b01);
    check("c1_data0", RdData0_o, 2);
    tick();
    settle("contend c2");
    check("c2_gnt", {Gnt1_o, Gnt0_o}, 2'b01);
    check("c2_rdv", {RdValid1_o, RdValid0_o}, 2'b10);
    check("c2_data1", RdData1_o, 3);
    tick();
    settle("contend c3");
    check("c3_gnt", {Gnt1_o, Gnt0_o}, 2'b10);
    check("c3_rdv", {RdValid1_o, RdValid0_o}, 2'b01);
    check("c3_data0", RdData0_o, 2);
    tick();
    Req0_i = 0; Req1_i = 0;
    settle("contend drain");
    check("c4_rdv", {RdValid1_o, RdValid0_o}, 2'b10);
    check("c4_data1", RdData1_o, 3);

    // Port 0 read of addr 5 leaves the pointer at port 1 before the sweep
    tick();
    Req0_i = 1; Addr0_i = 4'd5;
    settle("p0 pre-clear read");
    check("pre_gnt0", Gnt0_o, 1);
    tick();
    Req0_i = 1; Addr0_i = 4'd4; Req1_i = 1; Addr1_i = 4'd4;
    Clear_i = 1;
    settle("clear entry");
    check("ent_gnt", {Gnt1_o, Gnt0_o}, 0);
    check("ent_memwr", Mem_WR_o, 0);
    check("ent_busy", Busy_o, 0);
    check("ent_rdv0", RdValid0_o, 1);
    check("ent_data0", RdData0_o, 6);
    tick();
    Clear_i = 0;
    for (int k = 0; k < 2**AW; k++) begin
      settle("sweep");
      check("sw_busy", Busy_o, 1);
      check("sw_gnt", {Gnt1_o, Gnt0_o}, 0);
      check("sw_wr", Mem_WR_o, 1);
      check("sw_addr", Mem_Addr_o, k);
      check("sw_data", Mem_Data_o, 0);
      if (k == 0) check("sw_rdv0_clr", RdValid0_o, 0);
      tick();
    end
    settle("sweep done");
    check("dn_busy", Busy_o, 0);
    check("dn_done", ClearDone_o, 1);
    check("dn_gnt_ptr_kept", {Gnt1_o, Gnt0_o}, 2'b10);
    check("dn_addr", Mem_Addr_o, 4);
    tick();
    settle("post sweep");
    check("ps_done", ClearDone_o, 0);
    check("ps_gnt", {Gnt1_o, Gnt0_o}, 2'b01);
    check("ps_rdv1", RdValid1_o, 1);
    check("ps_data1", RdData1_o, 0);
    tick();
    Req0_i = 0; Req1_i = 0;
    settle("post sweep drain");
    check("ps_rdv0", RdValid0_o, 1);
    check("ps_data0", RdData0_o, 0);

    // Clear held high across the end of a sweep restarts it immediately
    tick();
    Clear_i = 1; Req0_i = 1;
    settle("clear held entry");
    check("h_gnt", Gnt0_o, 0);
    tick();
    for (int k = 0; k < 2**AW; k++) tick();
    settle("clear held return");
    check("h_done", ClearDone_o, 1);
    check("h_busy", Busy_o, 0);
    check("h_gnt_ret", {Gnt1_o, Gnt0_o}, 0);
    check("h_wr_ret", Mem_WR_o, 0);
    tick();
    Clear_i = 0;
    settle("restarted sweep");
    check("h_busy2", Busy_o, 1);
    check("h_addr2", Mem_Addr_o, 0);
    check("h_done2", ClearDone_o, 0);

    // Reset at counter 7 abandons the sweep and restores the pointer
    for (int k = 0; k < 7; k++) tick();
    settle("sweep at 7");
    check("m_addr7", Mem_Addr_o, 7);
    Reset_n_i = 1'b0;
    Req0_i = 0;
    settle("reset mid-sweep");
    check("m_busy", Busy_o, 0);
    check("m_wr", Mem_WR_o, 0);
    tick();
    Reset_n_i = 1'b1;
    for (int k = 0; k < 2**AW + 2; k++) begin
      settle("after reset");
      check("m_no_done", ClearDone_o, 0);
      check("m_no_busy", Busy_o, 0);
      tick();
    end
    Req0_i = 1; Req1_i = 1; Addr0_i = 4'd0; Addr1_i = 4'd0;
    settle("ptr after reset");
    check("m_ptr0", {Gnt1_o, Gnt0_o}, 2'b01);
    tick();
    Req0_i = 0; Req1_i = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Two-requester round-robin arbiter and clear sequencer in front of one single-port synchronous memory.
- Memory contract: one command per cycle; read data is registered, 1-cycle latency, read-before-write.
- Muxes each requester's address, data and write-enable onto the memory port and returns read data with a per-port valid strobe.
- Clear_i runs a full-array zero-fill sweep; requesters are stalled for its duration.

Parameters:
- AddrWidth, 4, memory address width; Size = 2**AddrWidth.
- DataWidth, 4, memory data width.

Ports:
- Clk_i  in  1  clock, all state on rising edge.
- Reset_n_i  in  1  reset, asynchronous, active-low.
- Req0_i  in  1  port 0 request.
- We0_i  in  1  port 0 write (1) / read (0).
- Addr0_i  in  AddrWidth  port 0 address.
- Data0_i  in  DataWidth  port 0 write data.
- Gnt0_o  out  1  port 0 grant; command issued this cycle.
- RdValid0_o  out  1  port 0 read data valid.
- RdData0_o  out  DataWidth  port 0 read data.
- Req1_i, We1_i, Addr1_i, Data1_i, Gnt1_o, RdValid1_o, RdData1_o: same as port 0, for port 1.
- Clear_i  in  1  start zero-fill sweep (level, sampled).
- Busy_o  out  1  sweep in progress.
- ClearDone_o  out  1  one-cycle pulse after the sweep ends.
- Mem_Addr_o  out  AddrWidth  memory address.
- Mem_Data_o  out  DataWidth  memory write data.
- Mem_WR_o  out  1  memory write enable.
- Mem_Data_i  in  DataWidth  memory registered read data.

Behaviour:
- Reset: Reset_n_i, asynchronous, active-low; clock Clk_i.
- Reset values:
  - state RUN;
  - priority pointer to port 0;
  - sweep counter 0;
  - RdValid0_o, RdValid1_o, Busy_o, ClearDone_o = 0;
  - Gnt0_o, Gnt1_o = 0 (no requests);
  - Mem_WR_o = 0.
- Handshake:
  - A transfer occurs in a cycle with ReqN_i & GntN_o.
  - The requester holds We/Addr/Data stable while ReqN_i=1 and GntN_o=0.
  - Gnt is combinational from the Req inputs, state and pointer.
- RUN state, arbitration:
  - At most one grant per cycle.
  - One request pending: grant it.
  - Both pending: grant the port holding the priority pointer.
  - After any grant, the pointer moves to the other port. This guarantees fairness: back-to-back dual requests alternate 0,1,0,1.
- RUN state, memory port:
  - Granted port drives Mem_Addr_o / Mem_Data_o; Mem_WR_o = granted We.
  - No grant: Mem_Addr_o=0, Mem_Data_o=0, Mem_WR_o=0.
- Read return:
  - A read granted in cycle t gives RdValidN_o=1 in cycle t+1, with RdDataN_o = Mem_Data_i (pass-through).
  - Writes produce no RdValid.
  - RdData of the non-valid port is don't-care; drive Mem_Data_i.
  - Read and write to the same address in consecutive cycles: the read in t+1 returns the t write (memory ordering).
- Clear entry:
  - RUN with Clear_i=1: no grants that cycle (Clear wins over requests); next state CLEAR, counter=0.
- CLEAR state:
  - Busy_o=1, Mem_WR_o=1, Mem_Addr_o=counter, Mem_Data_o=0.
  - Counter increments each cycle; all grants held at 0.
  - After the cycle with counter=Size-1, return to RUN. The sweep is exactly Size cycles.
  - ClearDone_o=1 for the first RUN cycle after the sweep.
  - Clear_i during CLEAR is ignored.
  - Clear_i still high on return to RUN starts a new sweep. No grant is issued that cycle; ClearDone_o still pulses.
- Read in flight at clear entry: a read granted the cycle before CLEAR still returns RdValid in the first CLEAR cycle.
- Priority pointer is unchanged by a sweep.
- Reset mid-sweep: immediate return to reset values; the sweep is abandoned and no ClearDone_o pulse.

Test Plan:
- Reset, idle: Reset_n_i low then high, no Req -> Gnt*=0, RdValid*=0, Busy_o=0, Mem_WR_o=0, Mem_Addr_o=0.
- Write/read, port 0: Req0 We0=1 Addr=3 Data=A -> Gnt0 same cycle, Mem_WR_o=1. Then Req0 read Addr=3 -> RdValid0_o=1 next cycle, RdData0_o=A.
- Contention: Req0 and Req1 both held high with reads to addr 1 and 2 for 4 cycles -> grants 0,1,0,1; RdValid alternates one cycle later with the matching data.
- Priority memory: single Req1 grant, then simultaneous Req0+Req1 -> Gnt0 first.
- Clear sweep: memory preloaded nonzero, Clear_i pulse while Req1 high -> Gnt1=0 for 16 cycles (default AddrWidth). Mem_Addr_o steps 0..15 with WR=1, Data=0. Then ClearDone_o pulses and Gnt1=1; read of any address returns 0.
- Reset mid-sweep: assert Reset_n_i low at counter=7 -> Busy_o=0 immediately. After release: RUN, pointer at port 0, no ClearDone_o.
